// File: rtl/audio_resamp_pkg.sv
// audio_resamp_pkg: shared types, step calculation and saturation for the linear resampler.
package audio_resamp_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    function automatic longint calc_step(input longint fin, input longint fout, input int fw);
        return ((fin << fw) + fout / 2) / fout;
    endfunction

    function automatic logic signed [63:0] sat_iw(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: small synchronous FIFO; a push while full succeeds only alongside a pop.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         wr, rd;

    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign empty = wp_q == rp_q;
    assign full  = wp_q == (rp_q ^ {1'b1, {AW{1'b0}}});
    assign dout  = empty ? '0 : mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + {{AW{1'b0}}, wr};
            rp_q <= rp_q + {{AW{1'b0}}, rd};
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/audio_linear_resampler.sv
// audio_linear_resampler: phase-accumulator linear interpolator between the two newest
// input samples, feeding an output FIFO with valid/ready toward the mixer.
module audio_linear_resampler
    import audio_resamp_pkg::*;
#(
    parameter int IW           = 16,
    parameter int FW           = 16,
    parameter int DATA_CLK_IN  = 300000,
    parameter int DATA_CLK_OUT = 48000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [IW-1:0] out_data,
    input  logic                 err_clr,
    output logic                 ovf_err,
    output logic                 drop_err
);

    localparam int PW = FW + 8;
    localparam int RW = IW + FW + 3;
    localparam longint STEP = calc_step(longint'(DATA_CLK_IN), longint'(DATA_CLK_OUT), FW);
    localparam logic [PW-1:0] ONE = PW'(1) << FW;
    localparam logic [PW-1:0] STEP_P = PW'(STEP);
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FW - 1);

    if (STEP < (longint'(1) << FW)) begin : g_bad_step
        $error("audio_linear_resampler: upsampling (STEP < 1.0) is not supported");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("audio_linear_resampler: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t                 state_q, state_d;
    logic signed [IW-1:0]   x0_q, x0_d, x1_q, x1_d;
    logic [PW-1:0]          pos_q, pos_d, pos_dec;
    logic signed [IW:0]     diff;
    logic signed [FW:0]     mu;
    logic signed [IW+FW+1:0] prod_q, prod_d;
    logic signed [RW-1:0]   y_full;
    logic signed [IW-1:0]   y;
    logic                   push, pop, full, empty, ovf_q, drop_q;

    assign diff    = x0_q - x1_q;
    assign mu      = {1'b0, pos_q[FW-1:0]};
    assign pos_dec = pos_q - ONE;
    // Round half up on the weighted difference before adding back the older sample.
    assign y_full  = RW'(x1_q) + ((RW'(prod_q) + HALF) >>> FW);
    assign y       = IW'(sat_iw(64'(y_full), IW));
    assign pop       = out_ready && !empty;
    assign out_valid = !empty;
    assign ovf_err   = ovf_q;
    assign drop_err  = drop_q;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        pos_d   = pos_q;
        prod_d  = prod_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                x1_d    = x0_q;
                x0_d    = in_data;
                pos_d   = pos_dec;
                state_d = pos_dec < ONE ? MUL : IDLE;
            end
            MUL: begin
                prod_d  = diff * mu;
                state_d = OUT;
            end
            default: begin
                push    = 1'b1;
                pos_d   = pos_q + STEP_P;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            pos_q   <= ONE;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            pos_q   <= pos_d;
            prod_q  <= prod_d;
            ovf_q   <= (push && full && !pop) || (ovf_q && !err_clr);
            drop_q  <= (in_valid && state_q != IDLE) || (drop_q && !err_clr);
        end
    end

    audio_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(IW)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  (y),
        .full (full),
        .pop  (pop),
        .dout (out_data),
        .empty(empty)
    );

endmodule

// File: tb/tb_audio_linear_resampler.sv
// tb_audio_linear_resampler: directed and random stimulus against a real-arithmetic
// interpolation model with an expected-output queue.
module tb_audio_linear_resampler;
    import audio_resamp_pkg::*;

    localparam int     DEPTH = 4;
    localparam longint ONE   = 65536;
    localparam longint STEP  = 409600;

    logic                clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    sample_t             in_data = '0;
    logic                out_valid, ovf_err, drop_err;
    logic signed [15:0]  out_data;

    int     n_chk = 0, n_pass = 0;
    int     exp_q[$], got[$];
    longint m_pos = ONE;
    int     m_x0 = 0, m_x1 = 0;
    bit     exp_ovf = 1'b0, exp_drop = 1'b0, rnd = 1'b0;

    always #5 clk = ~clk;

    audio_linear_resampler dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_clr  (err_clr),
        .ovf_err  (ovf_err),
        .drop_err (drop_err)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Output position lies fraction pos/2^16 of the way from the older to the newer sample.
    function automatic void model_in(input int d);
        real y;
        m_x1 = m_x0;
        m_x0 = d;
        m_pos -= ONE;
        if (m_pos >= ONE) return;
        y = $floor(real'(m_x1) + real'(m_x0 - m_x1) * real'(m_pos) / 65536.0 + 0.5);
        if (y > 32767.0) y = 32767.0;
        if (y < -32768.0) y = -32768.0;
        if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(int'(y));
        m_pos += STEP;
    endfunction

    function automatic void model_reset();
        m_pos = ONE;
        m_x0 = 0;
        m_x1 = 0;
        exp_q.delete();
        got.delete();
        exp_ovf = 1'b0;
        exp_drop = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got.push_back(int'(out_data));
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic pulse(input sample_t d);
        in_valid = 1'b1;
        in_data = d;
        model_in(d);
        wait_cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic feed(input sample_t d);
        pulse(d);
        wait_cyc(177);
        check("ovf_err", ovf_err, exp_ovf);
        check("drop_err", drop_err, exp_drop);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_drop", drop_err, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
    endtask

    task automatic to_next_output();
        for (int i = 0; i < 10 && m_pos - ONE >= ONE; i++) feed(sample_t'($urandom));
    endtask

    task automatic err_clear();
        err_clr = 1'b1;
        exp_ovf = 1'b0;
        exp_drop = 1'b0;
        wait_cyc(1);
        err_clr = 1'b0;
        check("clr_ovf", ovf_err, 0);
        check("clr_drop", drop_err, 0);
    endtask

    task automatic check_got(input string tag, input int v0, input int v1, input int v2);
        int v[3];
        v = '{v0, v1, v2};
        check({tag, "_n"}, got.size(), 3);
        for (int i = 0; i < 3; i++) check(tag, i < got.size() ? got[i] : -99999, v[i]);
    endtask

    task automatic ramp();
        for (int k = 0; k <= 12; k++) feed(sample_t'(100 * k));
        check_got("ramp", 0, 525, 1150);
    endtask

    initial begin
        do_reset();

        pulse(sample_t'(0));
        check("lat_mul", out_valid, 0);
        wait_cyc(1);
        check("lat_out", out_valid, 0);
        wait_cyc(1);
        check("lat_n3", out_valid, 1);
        check("lat_data", out_data, 0);
        out_ready = 1'b1;
        wait_cyc(175);
        for (int k = 1; k <= 12; k++) feed(sample_t'(100 * k));
        check_got("ramp", 0, 525, 1150);

        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 13; k++)
            feed(sample_t'((k == 6 || k == 7 || k == 13) ? 32767 : (k == 12) ? -32768 : 0));
        check_got("sat", 0, 32767, 0);

        do_reset();
        rnd = 1'b1;
        repeat (200) feed(sample_t'($urandom));
        rnd = 1'b0;
        out_ready = 1'b1;
        wait_cyc(10);
        check("rnd_drain", exp_q.size(), 0);

        to_next_output();
        in_valid = 1'b1;
        in_data = sample_t'(1234);
        model_in(1234);
        wait_cyc(1);
        in_data = sample_t'(-999);
        exp_drop = 1'b1;
        wait_cyc(1);
        in_valid = 1'b0;
        wait_cyc(176);
        check("busy_drop", drop_err, 1);
        repeat (15) feed(sample_t'($urandom));
        err_clear();

        do_reset();
        out_ready = 1'b0;
        repeat (40) feed(sample_t'($urandom));
        check("bp_ovf", ovf_err, 1);
        check("bp_held", out_valid, 1);
        out_ready = 1'b1;
        wait_cyc(8);
        check("bp_drained", got.size(), 4);
        check("bp_queue", exp_q.size(), 0);
        check("bp_empty", out_valid, 0);
        err_clear();

        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() < 2; i++) feed(sample_t'($urandom));
        to_next_output();
        in_valid = 1'b1;
        in_data = sample_t'($urandom);
        wait_cyc(1);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        ramp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
